// File: rtl/host_spi_loader.sv
// SPI-slave boot loader: buffers a host code image, bursts it into the CPU.
// Optional checksum readback is enabled with `define LOADER_CKSUM_EN.
module host_spi_loader #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int SYNC  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [15:0] par,
  output logic [1:0]  cpu_rst,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_HALT  = 3'd0,
    S_PREP  = 3'd1,
    S_BURST = 3'd2,
    S_GAP   = 3'd3,
    S_RUN   = 3'd4
  } state_e;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [SYNC-1:0] sck_sq;
  logic [SYNC-1:0] cs_sq;
  logic [SYNC-1:0] mosi_sq;
  logic            sck_s;
  logic            cs_s;
  logic            mosi_s;
  logic            sck_prev_q;
  logic            cs_prev_q;
  logic            sck_rise;
  logic            sck_fall;
  logic            cs_fall;
  logic [3:0]      cnt_q;
  logic [14:0]     in_q;
  logic [15:0]     word_q;
  logic            word_v_q;
  logic [15:0]     out_q;
  logic            miso_q;
  logic            load_st;
  logic [15:0]     status;
  logic [15:0]     tx_word;

  state_e          state_q;
  state_e          state_d;
  logic [AW:0]     wr_ptr_q;
  logic [AW:0]     wr_ptr_d;
  logic [AW:0]     rd_ptr_q;
  logic [AW:0]     rd_ptr_d;
  logic            ovf_q;
  logic            ovf_d;
  logic            wmode_q;
  logic            wmode_d;
  logic            first_q;
  logic            first_d;
  logic [1:0]      cpu_rst_q;
  logic [1:0]      cpu_rst_d;
  logic [15:0]     par_q;
  logic [15:0]     par_d;
  logic            busy_q;
  logic            busy_d;
  logic            do_halt;

  logic            we;
  logic [AW-1:0]   waddr;
  logic [AW-1:0]   raddr;
  logic [15:0]     rdata_q;
  logic [15:0]     mem [DEPTH];

`ifdef LOADER_CKSUM_EN
  logic [15:0]     sum_q;
  logic [15:0]     sum_d;
  logic            csel_q;
  logic            csel_d;
`endif

  assign sck_s  = sck_sq[SYNC-1];
  assign cs_s   = cs_sq[SYNC-1];
  assign mosi_s = mosi_sq[SYNC-1];

  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  // A fall with a wrapped bit count is the first fall of a new word.
  assign load_st = ~cs_s & (cs_fall | (sck_fall & (cnt_q == 4'd0)));

  assign status = {ovf_q, state_q, 2'b00, 10'(wr_ptr_q)};

`ifdef LOADER_CKSUM_EN
  assign tx_word = csel_q ? sum_q : status;
`else
  assign tx_word = status;
`endif

  assign spi_miso = miso_q;
  assign par      = par_q;
  assign cpu_rst  = cpu_rst_q;
  assign busy     = busy_q;

  // SPI front end: synchronise, shift words in on rise, status out on fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sq     <= '0;
      cs_sq      <= '1;
      mosi_sq    <= '0;
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b1;
      cnt_q      <= '0;
      in_q       <= '0;
      word_q     <= '0;
      word_v_q   <= 1'b0;
      out_q      <= '0;
      miso_q     <= 1'b0;
    end else begin
      sck_sq     <= {sck_sq[SYNC-2:0], spi_sck};
      cs_sq      <= {cs_sq[SYNC-2:0], spi_cs_n};
      mosi_sq    <= {mosi_sq[SYNC-2:0], spi_mosi};
      sck_prev_q <= sck_s;
      cs_prev_q  <= cs_s;
      word_v_q   <= 1'b0;
      if (cs_s) begin
        cnt_q  <= '0;
        miso_q <= 1'b0;
      end else begin
        if (sck_rise) begin
          in_q  <= {in_q[13:0], mosi_s};
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            word_q   <= {in_q, mosi_s};
            word_v_q <= 1'b1;
          end
        end
        if (load_st) begin
          miso_q <= tx_word[15];
          out_q  <= {tx_word[14:0], 1'b0};
        end else if (sck_fall) begin
          miso_q <= out_q[15];
          out_q  <= {out_q[14:0], 1'b0};
        end
      end
    end
  end

  // Sequencer and frame decode; outputs are registered from this.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ovf_d     = ovf_q;
    wmode_d   = wmode_q;
    first_d   = first_q;
    cpu_rst_d = 2'b00;
    par_d     = '0;
    busy_d    = 1'b0;
    do_halt   = 1'b0;
    we        = 1'b0;
    waddr     = wr_ptr_q[AW-1:0];
    raddr     = '0;
`ifdef LOADER_CKSUM_EN
    sum_d     = sum_q;
    csel_d    = csel_q & ~load_st;
`endif

    unique case (state_q)
      S_HALT: begin
      end
      S_PREP: begin
        raddr    = '0;
        rd_ptr_d = '0;
        busy_d   = 1'b1;
        state_d  = S_BURST;
      end
      S_BURST: begin
        raddr     = rd_ptr_q[AW-1:0] + 1'b1;
        rd_ptr_d  = rd_ptr_q + 1'b1;
        cpu_rst_d = 2'b01;
        par_d     = rdata_q;
        busy_d    = 1'b1;
        if (rd_ptr_q + 1'b1 == wr_ptr_q)
          state_d = S_GAP;
      end
      S_GAP: begin
        busy_d  = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        cpu_rst_d = 2'b10;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase

    if (cs_s) begin
      first_d = 1'b1;
      wmode_d = 1'b0;
    end

    if (word_v_q) begin
      if (first_q) begin
        first_d = 1'b0;
        wmode_d = 1'b0;
        case (word_q)
          16'h0000: do_halt = 1'b1;
          16'h0001: wmode_d = 1'b1;
          16'h0002: begin
            if (state_q == S_HALT && wr_ptr_q != '0)
              state_d = S_PREP;
          end
`ifdef LOADER_CKSUM_EN
          16'h0003: csel_d = 1'b1;
`endif
          default: begin
          end
        endcase
      end else if (wmode_q &&
                   (state_q == S_HALT || state_q == S_RUN)) begin
        if (wr_ptr_q == FULL) begin
          ovf_d = 1'b1;
        end else begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
`ifdef LOADER_CKSUM_EN
          sum_d    = sum_q + word_q;
`endif
        end
      end
    end

    if (do_halt) begin
      state_d   = S_HALT;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      ovf_d     = 1'b0;
      cpu_rst_d = 2'b00;
      par_d     = '0;
      busy_d    = 1'b0;
`ifdef LOADER_CKSUM_EN
      sum_d     = '0;
`endif
    end
  end

  // Control state and registered CPU-facing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_HALT;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovf_q     <= 1'b0;
      wmode_q   <= 1'b0;
      first_q   <= 1'b1;
      cpu_rst_q <= 2'b00;
      par_q     <= '0;
      busy_q    <= 1'b0;
`ifdef LOADER_CKSUM_EN
      sum_q     <= '0;
      csel_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ovf_q     <= ovf_d;
      wmode_q   <= wmode_d;
      first_q   <= first_d;
      cpu_rst_q <= cpu_rst_d;
      par_q     <= par_d;
      busy_q    <= busy_d;
`ifdef LOADER_CKSUM_EN
      sum_q     <= sum_d;
      csel_q    <= csel_d;
`endif
    end
  end

  // Image buffer: one write port, synchronous read with 1-cycle latency.
  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= word_q;
    rdata_q <= mem[raddr];
  end

endmodule

// File: tb/tb_host_spi_loader.sv
// Directed bench for host_spi_loader: status vectors, boot bursts,
// overflow on a 4-word instance, mid-burst halt, checksum readback.
module tb_host_spi_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sck;
  logic        spi_mosi;
  logic        cs_a;
  logic        cs_b;
  logic        miso_a;
  logic        miso_b;
  logic [15:0] par_a;
  logic [15:0] par_b;
  logic [1:0]  cpu_a;
  logic [1:0]  cpu_b;
  logic        busy_a;
  logic        busy_b;

  always #5 clk = ~clk;

  host_spi_loader dut_a (
    .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_cs_n(cs_a),
    .spi_mosi(spi_mosi), .spi_miso(miso_a), .par(par_a),
    .cpu_rst(cpu_a), .busy(busy_a)
  );

  host_spi_loader #(.DEPTH(4), .AW(2), .SYNC(2)) dut_b (
    .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_cs_n(cs_b),
    .spi_mosi(spi_mosi), .spi_miso(miso_b), .par(par_b),
    .cpu_rst(cpu_b), .busy(busy_b)
  );

  typedef struct {
    int          n;
    logic [2:0][15:0] w;
    int          extra;
    logic [15:0] st;
    logic [1:0]  cpu;
  } vec_t;

  int          nerr = 0;
  int          nchk = 0;
  int          tsel = 0;
  int          hp = 50;
  logic [15:0] txw [0:299];
  logic [15:0] rxw [0:299];
  logic [15:0] exp_par [0:7];
  logic [1:0]  rec_cpu [0:1023];
  logic [15:0] rec_par [0:1023];
  logic        rec_busy [0:1023];
  int          rec_n = 0;
  logic        rec_on = 1'b0;
  vec_t        vt [6];
  logic [15:0] st;

  always @(negedge clk) begin
    if (rec_on && rec_n < 1024) begin
      rec_cpu[rec_n]  = tsel != 0 ? cpu_b : cpu_a;
      rec_par[rec_n]  = tsel != 0 ? par_b : par_a;
      rec_busy[rec_n] = tsel != 0 ? busy_b : busy_a;
      rec_n++;
    end
  end

  function automatic vec_t mkv(input int n, input logic [15:0] a,
                               input logic [15:0] b, input logic [15:0] c,
                               input int ex, input logic [15:0] s,
                               input logic [1:0] cp);
    vec_t v;
    v.n = n;
    v.w[0] = a;
    v.w[1] = b;
    v.w[2] = c;
    v.extra = ex;
    v.st = s;
    v.cpu = cp;
    return v;
  endfunction

  function automatic logic [31:0] pk(input int i);
    return {13'd0, rec_cpu[i], rec_busy[i], rec_par[i]};
  endfunction

  task chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task bitx(input logic b, output logic r);
    spi_mosi = b;
    #(hp);
    r = tsel != 0 ? miso_b : miso_a;
    spi_sck = 1'b1;
    #(hp);
    spi_sck = 1'b0;
  endtask

  task send_frame(input int n, input int extra);
    logic r;
    if (tsel != 0) cs_b = 1'b0;
    else cs_a = 1'b0;
    #100;
    for (int w = 0; w < n; w++) begin
      for (int i = 15; i >= 0; i--) begin
        bitx(txw[w][i], r);
        rxw[w][i] = r;
      end
    end
    for (int e = 0; e < extra; e++) bitx(1'b1, r);
    #(hp);
    cs_a = 1'b1;
    cs_b = 1'b1;
    #200;
  endtask

  task one_word(input logic [15:0] w);
    txw[0] = w;
    send_frame(1, 0);
  endtask

  task probe(output logic [15:0] s);
    txw[0] = 16'hFFFF;
    send_frame(1, 0);
    s = rxw[0];
  endtask

  task boot_rec;
    rec_n = 0;
    rec_on = 1'b1;
    one_word(16'h0002);
    #200;
    rec_on = 1'b0;
  endtask

  task chk_boot(input int n, input string nm);
    int k;
    k = -1;
    for (int i = 1; i < rec_n; i++)
      if (k < 0 && rec_busy[i]) k = i;
    if (k < 0 || k + n + 2 >= rec_n) begin
      nchk++;
      nerr++;
      $display("FAIL %s_window: got start %0d want a full busy pulse", nm, k);
    end else begin
      chk({nm, "_pre"}, pk(k-1), {13'd0, 2'b00, 1'b0, 16'h0});
      chk({nm, "_prep"}, pk(k), {13'd0, 2'b00, 1'b1, 16'h0});
      for (int j = 0; j < n; j++)
        chk({nm, "_burst"}, pk(k+1+j), {13'd0, 2'b01, 1'b1, exp_par[j]});
      chk({nm, "_gap"}, pk(k+n+1), {13'd0, 2'b00, 1'b1, 16'h0});
      chk({nm, "_run"}, pk(k+n+2), {13'd0, 2'b10, 1'b0, 16'h0});
      chk({nm, "_hold"}, pk(rec_n-1), {13'd0, 2'b10, 1'b0, 16'h0});
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int c01;
    int c10;
    int last;
    rst = 1'b1;
    spi_sck = 1'b0;
    spi_mosi = 1'b0;
    cs_a = 1'b1;
    cs_b = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_a", {12'd0, cpu_a, busy_a, miso_a, par_a}, 32'h0);
    chk("reset_b", {12'd0, cpu_b, busy_b, miso_b, par_b}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    vt[0] = mkv(1, 16'h0002, 16'h0, 16'h0, 0, 16'h0000, 2'b00);
    vt[1] = mkv(3, 16'h0001, 16'h1111, 16'h2222, 0, 16'h0002, 2'b00);
    vt[2] = mkv(3, 16'h0007, 16'h0001, 16'h5555, 0, 16'h0002, 2'b00);
    vt[3] = mkv(2, 16'h0001, 16'h3333, 16'h0, 0, 16'h0003, 2'b00);
    vt[4] = mkv(1, 16'h0000, 16'h0, 16'h0, 0, 16'h0000, 2'b00);
    vt[5] = mkv(2, 16'h0001, 16'h00AA, 16'h0, 7, 16'h0001, 2'b00);

    tsel = 0;
    for (int v = 0; v < 6; v++) begin
      for (int j = 0; j < vt[v].n; j++) txw[j] = vt[v].w[j];
      send_frame(vt[v].n, vt[v].extra);
      probe(st);
      chk($sformatf("vec%0d_status", v), st, vt[v].st);
      chk($sformatf("vec%0d_cpu", v), cpu_a, vt[v].cpu);
    end

    exp_par[0] = 16'h00AA;
    boot_rec();
    chk_boot(1, "boot1");

    one_word(16'h0000);
    chk("halt_cpu", cpu_a, 2'b00);
    txw[0] = 16'h0001;
    txw[1] = 16'h1234;
    txw[2] = 16'h8000;
    txw[3] = 16'hA001;
    send_frame(4, 0);
    exp_par[0] = 16'h1234;
    exp_par[1] = 16'h8000;
    exp_par[2] = 16'hA001;
    boot_rec();
    chk_boot(3, "boot3");

    one_word(16'h0002);
    chk("boot_in_run_cpu", cpu_a, 2'b10);
    probe(st);
    chk("run_status", st, 16'h4003);
    txw[0] = 16'h0001;
    txw[1] = 16'h7777;
    send_frame(2, 0);
    probe(st);
    chk("write_in_run_status", st, 16'h4004);
    chk("write_in_run_cpu", cpu_a, 2'b10);

    tsel = 1;
    one_word(16'h0000);
    txw[0] = 16'h0001;
    for (int i = 1; i <= 6; i++) txw[i] = 16'(i * 16'h0101);
    send_frame(7, 0);
    probe(st);
    chk("ovf_status", st, 16'h8004);
    for (int i = 0; i < 4; i++) exp_par[i] = 16'((i + 1) * 16'h0101);
    boot_rec();
    chk_boot(4, "bootb");
    probe(st);
    chk("ovf_run_status", st, 16'hC004);
    one_word(16'h0002);
    chk("bootb_in_run_cpu", cpu_b, 2'b10);

    tsel = 0;
    one_word(16'h0000);
    hp = 40;
    txw[0] = 16'h0001;
    for (int i = 1; i <= 250; i++) txw[i] = 16'(i);
    send_frame(251, 0);
    probe(st);
    chk("bulk_status", st, 16'h00FA);
    rec_n = 0;
    rec_on = 1'b1;
    one_word(16'h0002);
    one_word(16'h0000);
    #200;
    rec_on = 1'b0;
    hp = 50;
    c01 = 0;
    c10 = 0;
    last = -1;
    for (int i = 0; i < rec_n; i++) begin
      if (rec_cpu[i] == 2'b01) begin
        c01++;
        last = i;
      end
      if (rec_cpu[i] == 2'b10) c10++;
    end
    chk("halt_burst_cut", {31'd0, c01 > 0 && c01 < 250}, 32'd1);
    chk("halt_no_run", c10, 0);
    if (last >= 0 && last + 1 < rec_n)
      chk("halt_next_clk", pk(last + 1), {13'd0, 2'b00, 1'b0, 16'h0});
    else
      chk("halt_next_clk", last, 32'hFFFF_FFFF);
    probe(st);
    chk("halt_status", st, 16'h0000);

    one_word(16'h0000);
    txw[0] = 16'h0001;
    txw[1] = 16'hFFFF;
    txw[2] = 16'h0002;
    send_frame(3, 0);
    txw[0] = 16'h0003;
    txw[1] = 16'h0000;
    send_frame(2, 0);
`ifdef LOADER_CKSUM_EN
    chk("cksum_word", rxw[1], 16'h0001);
`else
    chk("cksum_word", rxw[1], 16'h0002);
`endif
    probe(st);
    chk("cksum_after_status", st, 16'h0002);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
